// File: rtl/bridge_gate_driver.sv
// Multi-leg half-bridge gate driver: complementary gates per leg with shared
// programmable dead time, minimum on-time, enable sequencing and latched fault.
//
// Per-leg states:
//   state  | meaning
//   S_OFF  | both gates low, waiting for enable with no latched fault
//   S_DT   | dead time, both gates low for D = max(i_deadtime,1) cycles
//   S_HIGH | high-side gate on, held for at least M = max(i_min_on,1) cycles
//   S_LOW  | low-side gate on, held for at least M cycles
module bridge_gate_driver #(
    parameter int N_LEG    = 2,
    parameter int DT_WIDTH = 10,
    parameter int MO_WIDTH = 10
) (
    input  logic                i_clock,
    input  logic                i_RESET,
    input  logic                i_enable,
    input  logic [N_LEG-1:0]    i_sigma,
    input  logic [DT_WIDTH-1:0] i_deadtime,
    input  logic [MO_WIDTH-1:0] i_min_on,
    input  logic                i_fault,
    input  logic                i_fault_clear,
    output logic [N_LEG-1:0]    o_gate_h,
    output logic [N_LEG-1:0]    o_gate_l,
    output logic                o_fault,
    output logic                o_active
);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_DT   = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } leg_state_t;

    leg_state_t          state_q [N_LEG];
    leg_state_t          state_d [N_LEG];
    logic [DT_WIDTH-1:0] dt_cnt  [N_LEG];
    logic [MO_WIDTH-1:0] on_cnt  [N_LEG];
    logic [DT_WIDTH-1:0] dt_load;
    logic [MO_WIDTH-1:0] on_load;
    logic                active_d;

    // Counters are loaded with target-1 so that terminal count 0 marks the
    // last cycle of the interval; a programmed 0 behaves like 1.
    assign dt_load = (i_deadtime == '0) ? '0 : i_deadtime - DT_WIDTH'(1);
    assign on_load = (i_min_on == '0) ? '0 : i_min_on - MO_WIDTH'(1);

    always_comb begin
        active_d = 1'b0;
        for (int k = 0; k < N_LEG; k++) begin
            state_d[k] = state_q[k];
            if (i_fault || !i_enable) begin
                state_d[k] = S_OFF;
            end else begin
                case (state_q[k])
                    S_OFF: begin
                        if (!o_fault) state_d[k] = S_DT;
                    end
                    S_DT: begin
                        if (dt_cnt[k] == '0) state_d[k] = i_sigma[k] ? S_HIGH : S_LOW;
                    end
                    S_HIGH: begin
                        if (on_cnt[k] == '0 && !i_sigma[k]) state_d[k] = S_DT;
                    end
                    S_LOW: begin
                        if (on_cnt[k] == '0 && i_sigma[k]) state_d[k] = S_DT;
                    end
                    default: state_d[k] = S_OFF;
                endcase
            end
            if (state_d[k] == S_HIGH || state_d[k] == S_LOW) active_d = 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_RESET) begin
            for (int k = 0; k < N_LEG; k++) begin
                state_q[k] <= S_OFF;
                dt_cnt[k]  <= '0;
                on_cnt[k]  <= '0;
            end
            o_gate_h <= '0;
            o_gate_l <= '0;
            o_fault  <= 1'b0;
            o_active <= 1'b0;
        end else begin
            for (int k = 0; k < N_LEG; k++) begin
                state_q[k]  <= state_d[k];
                o_gate_h[k] <= (state_d[k] == S_HIGH);
                o_gate_l[k] <= (state_d[k] == S_LOW);

                // Dead-time counter: captured on entry, frozen at terminal count.
                if (state_d[k] == S_DT && state_q[k] != S_DT) begin
                    dt_cnt[k] <= dt_load;
                end else if (state_d[k] == S_DT && dt_cnt[k] != '0) begin
                    dt_cnt[k] <= dt_cnt[k] - DT_WIDTH'(1);
                end else if (state_d[k] != S_DT) begin
                    dt_cnt[k] <= '0;
                end

                if ((state_d[k] == S_HIGH || state_d[k] == S_LOW) && state_d[k] != state_q[k]) begin
                    on_cnt[k] <= on_load;
                end else if ((state_d[k] == S_HIGH || state_d[k] == S_LOW) && on_cnt[k] != '0) begin
                    on_cnt[k] <= on_cnt[k] - MO_WIDTH'(1);
                end else if (state_d[k] != S_HIGH && state_d[k] != S_LOW) begin
                    on_cnt[k] <= '0;
                end
            end
            o_active <= active_d;

            if (i_fault) begin
                o_fault <= 1'b1;
            end else if (i_fault_clear && !i_enable) begin
                o_fault <= 1'b0;
            end
        end
    end

endmodule
